paddle_emu: RTL and testbench



---
 rtl/paddle_pkg.sv | 8 +
 rtl/paddle_oneshot_ch.sv | 86 ++++++++
 rtl/paddle_emu.sv | 46 ++++
 tb/tb_paddle_emu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// paddle_pkg: shared channel state type and default timing constants for the paddle one-shot emulator
package paddle_pkg;
  typedef enum logic {IDLE, TIMING} ch_state_e;
  localparam int LINE_CLKS_DEF   = 455;
  localparam int MIN_LINES_DEF   = 16;
  localparam int RANGE_LINES_DEF = 200;
  localparam int MAX_STEP_DEF    = 8;
endpackage

// File: rtl/paddle_oneshot_ch.sv
// paddle_oneshot_ch: one non-retriggerable 555-style one-shot; pulse length = (MIN_LINES + pos_eff) lines.
// Optional PAD_SLEW_EN: pos_eff slews toward the clamped request by at most MAX_STEP per trigger.
module paddle_oneshot_ch
  import paddle_pkg::*;
#(
  parameter int LINE_CLKS   = LINE_CLKS_DEF,
  parameter int MIN_LINES   = MIN_LINES_DEF,
  parameter int RANGE_LINES = RANGE_LINES_DEF,
  parameter int MAX_STEP    = MAX_STEP_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       trg_i,
  input  logic [7:0] pos_i,
  output logic       out_o
);
  localparam int CW = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
  localparam logic [CW-1:0] CLK_TOP = CW'(LINE_CLKS - 1);
  localparam logic [8:0] RANGE = 9'(RANGE_LINES);
  localparam logic [8:0] MIN   = 9'(MIN_LINES);

  // line_q is 9 bits wide, so the longest pulse must fit; a slew step must be positive
  if (MIN_LINES + RANGE_LINES > 511 || MAX_STEP < 1) begin : g_param_chk
    $error("paddle_oneshot_ch: MIN_LINES + RANGE_LINES must be <= 511 and MAX_STEP >= 1");
  end

  ch_state_e     state_q;
  logic [8:0]    line_q;
  logic [CW-1:0] clk_q;
  logic          out_q;
  logic [8:0]    tgt;
  logic [8:0]    pos_d;

  assign tgt = ({1'b0, pos_i} > RANGE) ? RANGE : {1'b0, pos_i};

`ifdef PAD_SLEW_EN
  localparam logic [8:0] STEP = 9'(MAX_STEP);
  logic [8:0] pos_q;
  logic [8:0] up;
  logic [8:0] dn;

  // move pos_eff toward the target by at most STEP; never overshoots, so it stays within 0..RANGE
  always_comb begin
    up    = tgt - pos_q;
    dn    = pos_q - tgt;
    pos_d = (tgt > pos_q) ? pos_q + ((up > STEP) ? STEP : up) : pos_q - ((dn > STEP) ? STEP : dn);
  end

  // remember pos_eff between triggers so the next slew starts from it
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) pos_q <= '0;
    else if (state_q == IDLE && trg_i) pos_q <= pos_d;
`else
  assign pos_d = tgt;
`endif

  // one-shot FSM: load (MIN + pos_eff) lines on a trigger in IDLE, count down lines of LINE_CLKS cycles
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      line_q  <= '0;
      clk_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (trg_i) begin
            state_q <= TIMING;
            line_q  <= MIN + pos_d;
            clk_q   <= CLK_TOP;
            out_q   <= 1'b1;
          end
        TIMING:
          if (clk_q != '0) clk_q <= clk_q - CW'(1);
          else if (line_q == 9'd1) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
          end else begin
            line_q <= line_q - 9'd1;
            clk_q  <= CLK_TOP;
          end
      endcase
    end

  assign out_o = out_q;
endmodule

// File: rtl/paddle_emu.sv
// paddle_emu: two paddle pot/555 one-shots answering the shared falling-edge trigger PAD_TRG_N.
// Optional feature macro: PAD_SLEW_EN (position slew limiting in each channel).
module paddle_emu
  import paddle_pkg::*;
#(
  parameter int LINE_CLKS   = LINE_CLKS_DEF,
  parameter int MIN_LINES   = MIN_LINES_DEF,
  parameter int RANGE_LINES = RANGE_LINES_DEF,
  parameter int MAX_STEP    = MAX_STEP_DEF
) (
  input  logic       CLK,
  input  logic       FPGA_RESET_N,
  input  logic       PAD_TRG_N,
  input  logic [7:0] PAD1_POS,
  input  logic [7:0] PAD2_POS,
  output logic       PAD1_OUT,
  output logic       PAD2_OUT
);
  logic trg_q;
  logic arm_q;
  logic trg_edge;

  // trigger history; arm_q masks the first cycle after reset so a trigger already low at release is not an edge
  always_ff @(posedge CLK or negedge FPGA_RESET_N)
    if (!FPGA_RESET_N) begin
      trg_q <= 1'b1;
      arm_q <= 1'b0;
    end else begin
      trg_q <= PAD_TRG_N;
      arm_q <= 1'b1;
    end

  assign trg_edge = arm_q & trg_q & ~PAD_TRG_N;

  paddle_oneshot_ch #(
    .LINE_CLKS(LINE_CLKS), .MIN_LINES(MIN_LINES), .RANGE_LINES(RANGE_LINES), .MAX_STEP(MAX_STEP)
  ) u_ch1 (
    .clk_i(CLK), .rst_ni(FPGA_RESET_N), .trg_i(trg_edge), .pos_i(PAD1_POS), .out_o(PAD1_OUT)
  );

  paddle_oneshot_ch #(
    .LINE_CLKS(LINE_CLKS), .MIN_LINES(MIN_LINES), .RANGE_LINES(RANGE_LINES), .MAX_STEP(MAX_STEP)
  ) u_ch2 (
    .clk_i(CLK), .rst_ni(FPGA_RESET_N), .trg_i(trg_edge), .pos_i(PAD2_POS), .out_o(PAD2_OUT)
  );
endmodule

// File: tb/tb_paddle_emu.sv
// tb_paddle_emu: randomized and directed bench for paddle_emu against a pulse-countdown reference model
module tb_paddle_emu;
  localparam int LC  = 5;
  localparam int MNL = 16;
  localparam int RNG = 200;
  localparam int MS  = 8;
`ifdef PAD_SLEW_EN
  localparam int L4 = 24 * LC;
`else
  localparam int L4 = 46 * LC;
`endif

  logic       clk;
  logic       rst_n;
  logic       trg;
  logic [7:0] pos1;
  logic [7:0] pos2;
  logic       o1;
  logic       o2;

  int checks = 0;
  int errors = 0;
  int rem[2] = '{0, 0};
  int pe[2]  = '{0, 0};
  logic m_prev = 1'b1;
  logic m_arm  = 1'b0;
  int cnt[2] = '{0, 0};
  int len[2] = '{0, 0};

  paddle_emu #(.LINE_CLKS(LC), .MIN_LINES(MNL), .RANGE_LINES(RNG), .MAX_STEP(MS)) dut (
    .CLK(clk), .FPGA_RESET_N(rst_n), .PAD_TRG_N(trg),
    .PAD1_POS(pos1), .PAD2_POS(pos2), .PAD1_OUT(o1), .PAD2_OUT(o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  function automatic int next_pos(input int cur, input int req);
    int t;
    t = (req > RNG) ? RNG : req;
`ifdef PAD_SLEW_EN
    cur = (t > cur) ? cur + (((t - cur) > MS) ? MS : (t - cur)) : cur - (((cur - t) > MS) ? MS : (cur - t));
`else
    cur = t;
`endif
    return cur;
  endfunction

  // reference: each channel has "cycles of high output left"; a trigger only counts when none are left
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 1'b1;
      m_arm  <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        rem[c] <= 0;
        pe[c]  <= 0;
      end
    end else begin
      m_prev <= trg;
      m_arm  <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (rem[c] > 0) rem[c] <= rem[c] - 1;
        else if (m_arm && m_prev && !trg) begin
          pe[c]  <= next_pos(pe[c], c ? int'(pos2) : int'(pos1));
          rem[c] <= (MNL + next_pos(pe[c], c ? int'(pos2) : int'(pos1))) * LC;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("pad1_out", {31'b0, o1}, {31'b0, rem[0] > 0});
    chk("pad2_out", {31'b0, o2}, {31'b0, rem[1] > 0});
  end

  // measured width of the most recent high pulse on each output
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (c ? o2 : o1) cnt[c] <= cnt[c] + 1;
      else if (cnt[c] > 0) begin
        len[c] <= cnt[c];
        cnt[c] <= 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o1 || o2) && n < 1500) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", {31'b0, n < 1500}, 1);
  endtask

  task automatic pulse_check(input string n, input int e1, input int e2);
    trg = 1'b1;
    tick(1);
    trg = 1'b0;
    tick(1);
    chk({n, "_rise1"}, {31'b0, o1}, 1);
    chk({n, "_rise2"}, {31'b0, o2}, 1);
    tick(3);
    trg = 1'b1;
    wait_idle();
    tick(2);
    chk({n, "_len1"}, len[0], e1);
    chk({n, "_len2"}, len[1], e2);
  endtask

  initial begin
    rst_n = 1'b0;
    trg   = 1'b1;
    pos1  = 8'd0;
    pos2  = 8'd0;
    tick(3);
    chk("reset_out1", {31'b0, o1}, 0);
    chk("reset_out2", {31'b0, o2}, 0);
    rst_n = 1'b1;
    tick(2);
`ifdef PAD_SLEW_EN
    pos1 = 8'd20;
    pos2 = 8'd0;
    pulse_check("slew1", 24 * LC, 16 * LC);
    pulse_check("slew2", 32 * LC, 16 * LC);
    pulse_check("slew3", 36 * LC, 16 * LC);
    pulse_check("slew4", 36 * LC, 16 * LC);
`else
    pos1 = 8'd0;
    pos2 = 8'd100;
    pulse_check("basic", 16 * LC, 116 * LC);
    pos1 = 8'd255;
    pos2 = 8'd255;
    pulse_check("clamp", 216 * LC, 216 * LC);
    pos1 = 8'd50;
    pos2 = 8'd0;
    trg = 1'b1;
    tick(1);
    trg = 1'b0;
    tick(4);
    trg = 1'b1;
    tick(195);
    pos1 = 8'd150;
    trg = 1'b0;
    tick(3);
    trg = 1'b1;
    wait_idle();
    tick(2);
    chk("retrig_len1", len[0], 66 * LC);
    chk("retrig_len2", len[1], 16 * LC);
    pulse_check("newpos", 166 * LC, 16 * LC);
`endif
    pos1 = 8'd30;
    pos2 = 8'd0;
    trg = 1'b1;
    tick(1);
    trg = 1'b0;
    tick(50);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst1", {31'b0, o1}, 0);
    chk("async_rst2", {31'b0, o2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    chk("no_pulse_release1", {31'b0, o1}, 0);
    chk("no_pulse_release2", {31'b0, o2}, 0);
    pulse_check("after_rst", L4, 16 * LC);
    pos1 = 8'd0;
    pos2 = 8'd0;
    trg = 1'b1;
    tick(1);
    trg = 1'b0;
    tick(1);
    chk("coincide_rise", {31'b0, o1}, 1);
    trg = 1'b1;
    tick(79);
    trg = 1'b0;
    tick(1);
    chk("coincide_low1", {31'b0, o1}, 0);
    chk("coincide_low2", {31'b0, o2}, 0);
    tick(10);
    chk("coincide_stay1", {31'b0, o1}, 0);
    chk("coincide_stay2", {31'b0, o2}, 0);
    chk("coincide_len", len[0], 16 * LC);
    trg = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pos1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 255));
      pos2 = 8'($urandom_range(0, 255));
      trg = 1'b1;
      tick($urandom_range(1, 3));
      trg = 1'b0;
      tick($urandom_range(1, 5));
      trg = 1'b1;
      tick($urandom_range(0, 700));
      pos1 = 8'($urandom);
      pos2 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
